mux_nx1_rr_mem: RTL and testbench
=================================

Name: mux_nx1_rr_mem

Overview:
Parametrised N:1 data multiplexer with a registered, valid-qualified output and output memory. When no valid data is selected, the last transferred word is held. Two run-time modes:
- selector-driven (generalises the existing 2x1 4-bit valid mux)
- round-robin arbitration over valid channels

Sits between N producer channels and a single consumer. Also provides a transfer counter for bench and debug visibility.

Parameters:
- WIDTH, 4, data width per channel in bits (>=1)
- CHANNELS, 4, number of input channels (>=2)
- COUNT_W, 8, width of the transfer counter
- SEL_W (localparam), $clog2(CHANNELS), width of selector and grant

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- mode  in  1  0 = selector mode, 1 = round-robin mode
- selector  in  SEL_W  channel select, used only when mode=0
- valid_in  in  CHANNELS  per-channel valid; bit i qualifies channel i
- data_in  in  CHANNELS*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH]
- data_out  out  WIDTH  registered selected data (memory: holds when nothing transferred)
- valid_out  out  1  high for one cycle per transferred word
- grant_out  out  SEL_W  channel index that produced current data_out
- count_out  out  COUNT_W  number of transfers since reset, wraps

Behaviour:
- Reset: asynchronous. While reset=1, all of the following are forced to 0 immediately, with no clock edge required: data_out, valid_out, grant_out, count_out, and the RR pointer.
  - Reset deasserting mid-stream: the first transfer can occur at the first rising edge after deassertion.
- Latency: 1 cycle. Inputs sampled at edge k appear on the outputs after edge k.
- A transfer happens at an edge when a channel is granted:
  - data_out <= that channel's data
  - grant_out <= index
  - valid_out <= 1
  - count_out <= count_out + 1, modulo 2^COUNT_W
- No transfer:
  - valid_out <= 0
  - data_out and grant_out hold
  - count_out holds
- Mode 0 (selector):
  - Grant = selector if selector < CHANNELS and valid_in[selector]=1; otherwise no transfer.
  - Selector >= CHANNELS (non-power-of-2 CHANNELS) means no transfer; not an error.
- Mode 1 (round-robin):
  - Pointer ptr (SEL_W bits) holds the first channel to consider.
  - Search ptr, ptr+1, ..., wrapping modulo CHANNELS; grant the first channel with valid_in=1.
  - On grant g: ptr <= (g+1) mod CHANNELS. Wrap from CHANNELS-1 to 0, including non-power-of-2 counts.
  - No valid channel: no transfer, ptr holds.
- ptr updates only in mode 1. Mode-0 transfers leave ptr untouched.
- Mode changes take effect at the next edge; no flush and no lost state.
- Other input changes between edges have no effect; only edge-sampled values count.
- There is no backpressure; a consumer that needs every word must accept one per cycle.

Decomposition:
- Shared package mux_pkg:
  - MODE_SEL=1'b0, MODE_RR=1'b1
  - function clog2 for SEL_W if the toolflow lacks $clog2
- One sub-module: rr_arbiter.
  - Parameter CHANNELS.
  - Inputs: clk, reset, enable (=mode), req (=valid_in).
  - Outputs: gnt_valid, gnt_idx.
  - Owns ptr and the rotating priority search.
- The top holds the output registers, the selector path and the counter.

Test Plan (CHANNELS=4, WIDTH=4, COUNT_W=4; data_in ch i = i+1 unless stated):
1. Reset: pulse reset=1 between edges during an active stream -> data_out, valid_out, grant_out and count_out read 0 before the next edge. Release -> transfer on the next edge.
2. Mode 0, selector=2, valid_in=4'b0100, ch2=4'hA -> after edge: data_out=A, valid_out=1, grant_out=2, count_out=1. Then valid_in=0 -> data_out=A, valid_out=0, count_out=1.
3. Mode 0, selector=1, valid_in=4'b0100 -> valid_out=0; data_out and grant_out unchanged from the prior value.
4. Mode 1, valid_in=4'b1111 for 5 cycles -> grant_out 0,1,2,3,0; data_out 1,2,3,4,1; valid_out=1 each cycle.
5. Mode 1 wrap/skip: after grant 2 (ptr=3), valid_in=4'b0011 -> grants 0,1,0; valid_in=0 next -> valid_out=0, ptr holds (next grant with valid_in=4'b0011 is 1).
6. Counter wrap: 17 consecutive transfers in mode 1 -> count_out=1. A mode switch 1->0 mid-sequence leaves ptr unchanged on return to mode 1.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the N:1 valid-qualified mux slice.
//   MODE_SEL / MODE_RR : encodings of the run-time mode input
//   clog2              : ceiling log2 for toolflows without $clog2
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority arbiter over CHANNELS requesters.
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset (pointer -> 0)
//   enable    in   arbitration active; pointer only moves when high
//   req       in   per-channel request vector
//   gnt_valid out  a request was granted this cycle (combinational)
//   gnt_idx   out  index of the granted channel (combinational)
module rr_arbiter #(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [CHANNELS-1:0] req,
    output logic                gnt_valid,
    output logic [SEL_W-1:0]    gnt_idx
);

    localparam int unsigned NCH = CHANNELS;

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             found;
    logic [SEL_W-1:0] pick;
    int unsigned      idx;

    // Search ptr, ptr+1, ... modulo CHANNELS; the first requester wins.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = (32'(ptr_q) + i) % NCH;
            if (!found && |(req & (CHANNELS'(1) << idx))) begin
                found = 1'b1;
                pick  = SEL_W'(idx);
            end
        end
    end

    // Explicit wrap so non-power-of-2 channel counts return to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (enable && found) begin
            ptr_d = (pick == SEL_W'(NCH - 1)) ? '0 : pick + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_valid = enable & found;
    assign gnt_idx   = pick;

endmodule

// File: rtl/mux_nx1_rr_mem.sv
// mux_nx1_rr_mem: N:1 valid-qualified data mux with registered output that
// holds the last transferred word, selector or round-robin channel choice,
// and a wrapping transfer counter.
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-high reset
//   mode      in   0 = selector mode, 1 = round-robin mode
//   selector  in   channel select (mode 0 only)
//   valid_in  in   per-channel valid
//   data_in   in   flattened channel data, ch i at [i*WIDTH +: WIDTH]
//   data_out  out  last transferred word
//   valid_out out  one-cycle pulse per transfer
//   grant_out out  channel that produced data_out
//   count_out out  transfers since reset, wrapping
module mux_nx1_rr_mem
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    parameter  int COUNT_W  = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS-1:0]       valid_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]          data_out,
    output logic                      valid_out,
    output logic [SEL_W-1:0]          grant_out,
    output logic [COUNT_W-1:0]        count_out
);

    logic                rr_valid;
    logic [SEL_W-1:0]    rr_idx;
    logic                sel_hit;
    logic                xfer;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    data_sel;

    logic [WIDTH-1:0]    data_q,  data_d;
    logic                valid_q, valid_d;
    logic [SEL_W-1:0]    grant_q, grant_d;
    logic [COUNT_W-1:0]  count_q, count_d;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .enable    (mode == MODE_RR),
        .req       (valid_in),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // A selector >= CHANNELS shifts the one-hot out of range, giving no hit.
    assign sel_hit   = |(valid_in & (CHANNELS'(1) << selector));
    assign xfer      = (mode == MODE_RR) ? rr_valid : sel_hit;
    assign grant_idx = (mode == MODE_RR) ? rr_idx   : selector;
    assign data_sel  = WIDTH'(data_in >> (32'(grant_idx) * WIDTH));

    always_comb begin
        data_d  = data_q;
        grant_d = grant_q;
        count_d = count_q;
        valid_d = 1'b0;
        if (xfer) begin
            data_d  = data_sel;
            grant_d = grant_idx;
            count_d = count_q + COUNT_W'(1);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            count_q <= count_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign grant_out = grant_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_mux_nx1_rr_mem.sv
module tb_mux_nx1_rr_mem;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int COUNT_W  = 4;
    localparam int SEL_W    = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      mode;
    logic [SEL_W-1:0]          selector;
    logic [CHANNELS-1:0]       valid_in;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [WIDTH-1:0]          data_out;
    logic                      valid_out;
    logic [SEL_W-1:0]          grant_out;
    logic [COUNT_W-1:0]        count_out;

    mux_nx1_rr_mem #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .selector  (selector),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .grant_out (grant_out),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic [1:0] g;
        logic [3:0] c;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int unsigned m_ptr;
    logic [3:0]  m_data;
    logic [1:0]  m_grant;
    logic [3:0]  m_count;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_data  = '0;
        m_grant = '0;
        m_count = '0;
    endtask

    // Predict the outcome of the coming edge, push it, run the edge, compare.
    task automatic step(input string tag);
        exp_t        e;
        exp_t        got;
        bit          hit;
        int unsigned g;
        hit = 0;
        g   = 0;
        if (mode == 1'b0) begin
            g   = selector;
            hit = (g < CHANNELS) && valid_in[g];
        end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                int unsigned c;
                c = (m_ptr + k) % CHANNELS;
                if (!hit && valid_in[c]) begin
                    hit = 1;
                    g   = c;
                end
            end
        end
        if (hit) begin
            m_data  = 4'(data_in >> (g * WIDTH));
            m_grant = 2'(g);
            m_count = m_count + 4'd1;
            if (mode == 1'b1) m_ptr = (g + 1) % CHANNELS;
        end
        e.v = hit;
        e.d = m_data;
        e.g = m_grant;
        e.c = m_count;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, ".valid"}, 32'(valid_out), 32'(got.v));
        check({tag, ".data"},  32'(data_out),  32'(got.d));
        check({tag, ".grant"}, 32'(grant_out), 32'(got.g));
        check({tag, ".count"}, 32'(count_out), 32'(got.c));
    endtask

    task automatic set_data(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
        data_in = {d3, d2, d1, d0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        mode     = 1'b0;
        selector = '0;
        valid_in = '0;
        set_data(4'h1, 4'h2, 4'h3, 4'h4);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.valid", 32'(valid_out), 32'd0);
        check("rst.data",  32'(data_out),  32'd0);
        check("rst.grant", 32'(grant_out), 32'd0);
        check("rst.count", 32'(count_out), 32'd0);
        reset = 1'b0;

        // Selector mode
        selector = 2'd2;
        valid_in = 4'b0100;
        set_data(4'h1, 4'h2, 4'hA, 4'h4);
        step("sel_hit");
        valid_in = 4'b0000;
        step("sel_idle");
        selector = 2'd1;
        valid_in = 4'b0100;
        step("sel_miss");
        selector = 2'd3;
        valid_in = 4'b1000;
        step("sel_ch3");

        // Round-robin, all valid
        set_data(4'h1, 4'h2, 4'h3, 4'h4);
        mode     = 1'b1;
        valid_in = 4'b1111;
        for (int i = 0; i < 5; i++) step("rr_all");
        // grants 1,2 -> ptr=3
        step("rr_all");
        step("rr_all");
        valid_in = 4'b0011;
        for (int i = 0; i < 3; i++) step("rr_skip");
        valid_in = 4'b0000;
        step("rr_idle");
        valid_in = 4'b0011;
        step("rr_hold");

        // Counter wrap with a selector-mode transfer in the middle
        valid_in = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            if (i == 8) begin
                mode     = 1'b0;
                selector = 2'd0;
                step("wrap_sel");
                mode     = 1'b1;
            end
            step("wrap_rr");
        end

        // Random traffic with mode flips
        for (int i = 0; i < 200; i++) begin
            mode     = ($urandom_range(0, 3) != 0);
            selector = 2'($urandom);
            valid_in = 4'($urandom);
            data_in  = 16'($urandom);
            step("rand");
        end

        // Asynchronous reset mid-stream, with ptr moved off zero first
        mode     = 1'b1;
        valid_in = 4'b0001;
        step("pre_rst");
        valid_in = 4'b1111;
        set_data(4'h1, 4'h2, 4'h3, 4'h4);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("arst.valid", 32'(valid_out), 32'd0);
        check("arst.data",  32'(data_out),  32'd0);
        check("arst.grant", 32'(grant_out), 32'd0);
        check("arst.count", 32'(count_out), 32'd0);
        reset = 1'b0;
        step("post_rst");
        step("post_rst2");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
